// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment message scanner: scan states,
// hex segment table and the blank pattern.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_LATCH,
        ST_SHOW
    } scan_state_t;

    // Active-high a..g patterns; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // All segments dark, active-high form.
    localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to {dp,g,f,e,d,c,b,a} decoder, active-high.
module hex_to_seven_seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {dp, HEX_LUT[nibble]};

endmodule

// File: rtl/seven_segment_buffer_scanner.sv
// Scans a message BRAM onto a multiplexed seven-segment display, one byte per
// digit, with an optional scrolling window applied at frame boundaries.
module seven_segment_buffer_scanner
    import seg7_pkg::*;
#(
    parameter int D_W         = 8,
    parameter int NS_BITS     = 9,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 4096,
    parameter int SCROLL_DIV  = 2**22,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NS_BITS:0]      msg_len,
    input  logic                  scroll_en,
    output logic                  rd_enable,
    output logic [NS_BITS-1:0]    rd_address,
    input  logic [D_W-1:0]        rd_data_in,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] digit_sel
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SC_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int LEN_W = NS_BITS + 1;

    localparam logic [LEN_W-1:0]      LEN_ONE   = LEN_W'(1);
    localparam logic [7:0]            SEG_BLANK = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] SEL_BLANK = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

    scan_state_t           state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [RC_W-1:0]       refresh_cnt, refresh_nxt;
    logic [SC_W-1:0]       scroll_cnt;
    logic                  scroll_pend, scroll_wrap;
    logic [LEN_W-1:0]      base, base_nxt, len_q, len_nxt;
    logic [LEN_W-1:0]      idx_ext, base_clamped, addr_sum, addr_mod;
    logic                  fetch_ok, fetch_ok_nxt, fetch_valid, at_boundary;
    logic                  rd_enable_nxt;
    logic [NS_BITS-1:0]    rd_address_nxt;
    logic [7:0]            seg_dec, seg_lit, seg_nxt;
    logic [NUM_DIGITS-1:0] sel_hot, sel_lit, sel_nxt;
    logic                  unused_data;

    hex_to_seven_seg u_decode (
        .nibble (rd_data_in[3:0]),
        .dp     (rd_data_in[7]),
        .seg    (seg_dec)
    );

    assign unused_data = ^rd_data_in;
    assign idx_ext     = LEN_W'(idx);
    assign at_boundary = (state == ST_FETCH) && (idx == '0);
    assign sel_hot     = NUM_DIGITS'(1) << idx;
    assign seg_lit     = (ACTIVE_LOW != 0) ? ~seg_dec : seg_dec;
    assign sel_lit     = (ACTIVE_LOW != 0) ? ~sel_hot : sel_hot;
    assign scroll_wrap = scroll_en && (scroll_cnt == SC_W'(SCROLL_DIV - 1));

    // At the frame boundary the fresh msg_len and adjusted base are used
    // directly, so the first digit of the frame already reads the new window.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        refresh_nxt    = refresh_cnt;
        base_nxt       = base;
        len_nxt        = len_q;
        fetch_ok_nxt   = fetch_ok;
        rd_enable_nxt  = 1'b0;
        rd_address_nxt = rd_address;
        seg_nxt        = seg_out;
        sel_nxt        = digit_sel;
        base_clamped   = base;

        if (at_boundary) begin
            len_nxt      = msg_len;
            base_clamped = (base >= msg_len) ? '0 : base;
            if (scroll_pend && (msg_len != '0))
                base_nxt = (base_clamped + LEN_ONE == msg_len) ? '0 : base_clamped + LEN_ONE;
            else
                base_nxt = base_clamped;
        end

        addr_sum    = base_nxt + idx_ext;
        addr_mod    = (addr_sum >= len_nxt) ? addr_sum - len_nxt : addr_sum;
        fetch_valid = (idx_ext < len_nxt);

        unique case (state)
            ST_FETCH: begin
                fetch_ok_nxt  = fetch_valid;
                rd_enable_nxt = fetch_valid;
                if (fetch_valid)
                    rd_address_nxt = addr_mod[NS_BITS-1:0];
                seg_nxt   = SEG_BLANK;
                sel_nxt   = SEL_BLANK;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                refresh_nxt = '0;
                if (fetch_ok) begin
                    seg_nxt = seg_lit;
                    sel_nxt = sel_lit;
                end
                state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                if (refresh_cnt == RC_W'(REFRESH_DIV - 1)) begin
                    seg_nxt   = SEG_BLANK;
                    sel_nxt   = SEL_BLANK;
                    idx_nxt   = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
                    state_nxt = ST_FETCH;
                end else begin
                    refresh_nxt = refresh_cnt + RC_W'(1);
                end
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            idx         <= '0;
            refresh_cnt <= '0;
            base        <= '0;
            len_q       <= '0;
            fetch_ok    <= 1'b0;
            rd_enable   <= 1'b0;
            rd_address  <= '0;
            seg_out     <= SEG_BLANK;
            digit_sel   <= SEL_BLANK;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            refresh_cnt <= refresh_nxt;
            base        <= base_nxt;
            len_q       <= len_nxt;
            fetch_ok    <= fetch_ok_nxt;
            rd_enable   <= rd_enable_nxt;
            rd_address  <= rd_address_nxt;
            seg_out     <= seg_nxt;
            digit_sel   <= sel_nxt;
        end
    end

    // A wrap coinciding with the boundary is kept for the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_cnt  <= '0;
            scroll_pend <= 1'b0;
        end else begin
            if (!scroll_en || scroll_wrap)
                scroll_cnt <= '0;
            else
                scroll_cnt <= scroll_cnt + SC_W'(1);

            if (scroll_wrap)
                scroll_pend <= 1'b1;
            else if (at_boundary)
                scroll_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seven_segment_buffer_scanner.sv
// Self-checking bench: a cycle-indexed behavioural model of the scan checks
// every output each cycle, plus literal checks of the documented scenarios.
module tb_seven_segment_buffer_scanner;

    localparam int NS_BITS = 9;
    localparam int D_W     = 8;
    localparam int ND      = 4;
    localparam int RDIV    = 4;
    localparam int SDIV    = 64;
    localparam int PERIOD  = RDIV + 3;
    localparam int FRAME   = PERIOD * ND;

    logic               clk = 1'b0;
    logic               rst;
    logic [NS_BITS:0]   msg_len;
    logic               scroll_en;
    logic               rd_enable;
    logic [NS_BITS-1:0] rd_address;
    logic [D_W-1:0]     rd_data_in;
    logic [7:0]         seg_out;
    logic [ND-1:0]      digit_sel;

    logic [7:0] mem [512];
    logic [6:0] hex_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int vectors     = 0;
    int miscompares = 0;
    int fail_prints = 0;

    // Model state: cycle index since reset release, frame window and scroll.
    bit m_live = 0;
    int m_t    = 0;
    int m_base = 0;
    int m_len  = 0;
    bit m_pend = 0;
    int m_run  = 0;

    seven_segment_buffer_scanner #(
        .D_W         (D_W),
        .NS_BITS     (NS_BITS),
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RDIV),
        .SCROLL_DIV  (SDIV),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .msg_len    (msg_len),
        .scroll_en  (scroll_en),
        .rd_enable  (rd_enable),
        .rd_address (rd_address),
        .rd_data_in (rd_data_in),
        .seg_out    (seg_out),
        .digit_sel  (digit_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_enable)
            rd_data_in <= mem[rd_address];
    end

    task automatic check_value(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            if (fail_prints < 40)
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
            fail_prints++;
        end
    endtask

    function automatic logic [7:0] lit_pattern(input logic [7:0] b);
        return ~{b[7], hex_lut[b[3:0]]};
    endfunction

    // Per-cycle reference: digit and phase follow from the cycle index alone.
    always @(negedge clk) begin
        int  d, ph, a;
        bit  wrap;
        bit  exp_en;
        logic [7:0] exp_seg;
        logic [3:0] exp_sel;
        if (m_live) begin
            d       = (m_t / PERIOD) % ND;
            ph      = m_t % PERIOD;
            exp_en  = 0;
            exp_seg = 8'hFF;
            exp_sel = 4'hF;
            a       = 0;
            if (d < m_len) begin
                a = (m_base + d) % m_len;
                if (ph == 1) exp_en = 1;
                if (ph >= 3) begin
                    exp_seg = lit_pattern(mem[a]);
                    exp_sel = ~(4'(1 << d));
                end
            end
            check_value("model rd_enable", int'(rd_enable), int'(exp_en));
            if (exp_en)
                check_value("model rd_address", int'(rd_address), a);
            check_value("model seg_out", int'(seg_out), int'(exp_seg));
            check_value("model digit_sel", int'(digit_sel), int'(exp_sel));
        end
        if (rst) begin
            m_live = 1;
            m_t    = 0;
            m_base = 0;
            m_len  = 0;
            m_pend = 0;
            m_run  = 0;
        end else if (m_live) begin
            wrap = 0;
            if (scroll_en) begin
                m_run++;
                if (m_run == SDIV) begin
                    wrap  = 1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if (m_t % FRAME == 0) begin
                m_len = int'(msg_len);
                if (m_base >= m_len) m_base = 0;
                if (m_pend && m_len != 0) m_base = (m_base + 1) % m_len;
                m_pend = wrap;
            end else if (wrap) begin
                m_pend = 1;
            end
            m_t++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame_start();
        bit found = 0;
        for (int c = 0; c < 3 * FRAME && !found; c++) begin
            tick();
            if (m_t % FRAME == 0) found = 1;
        end
        if (!found) check_value("frame start timeout", 0, 1);
    endtask

    task automatic show_check(input string name, input logic [3:0] pat, input logic [7:0] seg);
        bit found = 0;
        for (int c = 0; c < 3 * FRAME && !found; c++) begin
            if (digit_sel == pat) found = 1;
            else tick();
        end
        check_value({name, " found"}, int'(found), 1);
        check_value(name, int'(seg_out), int'(seg));
    endtask

    task automatic capture_reads(input string name, input int n, input int exp_addr [4]);
        int got = 0;
        for (int c = 0; c < FRAME + 4 && got < n; c++) begin
            tick();
            if (rd_enable) begin
                check_value(name, int'(rd_address), exp_addr[got]);
                got++;
            end
        end
        if (got < n) check_value({name, " timeout"}, got, n);
    endtask

    task automatic seek_base(input int target);
        bit found = 0;
        for (int c = 0; c < 4000 && !found; c++) begin
            tick();
            if (m_base == target && !m_pend) begin
                found     = 1;
                scroll_en = 0;
            end
        end
        check_value("seek base", int'(found), 1);
    endtask

    function automatic logic [NS_BITS:0] pick_len();
        if ($urandom_range(0, 9) == 9)
            return (NS_BITS+1)'(510 + $urandom_range(0, 2));
        return (NS_BITS+1)'($urandom_range(0, 8));
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int run_len, blank_len, pulses, lit;
        rst       = 1;
        scroll_en = 0;
        msg_len   = 4;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h00;
        mem[1] = 8'h01;
        mem[2] = 8'h0A;
        mem[3] = 8'h8F;

        repeat (3) tick();
        check_value("reset rd_enable", int'(rd_enable), 0);
        check_value("reset rd_address", int'(rd_address), 0);
        check_value("reset seg_out", int'(seg_out), 8'hFF);
        check_value("reset digit_sel", int'(digit_sel), 4'hF);
        rst = 0;

        show_check("digit0 seg", 4'b1110, 8'hC0);
        run_len = 0;
        while (digit_sel == 4'b1110 && run_len < 20) begin
            run_len++;
            tick();
        end
        check_value("digit0 lit clocks", run_len, 4);
        blank_len = 0;
        while (digit_sel == 4'b1111 && blank_len < 20) begin
            blank_len++;
            tick();
        end
        check_value("gap blank clocks", blank_len, 3);
        show_check("digit1 seg", 4'b1101, 8'hF9);
        show_check("digit2 seg", 4'b1011, 8'h88);
        show_check("digit3 seg", 4'b0111, 8'h0E);

        msg_len   = 6;
        scroll_en = 1;
        seek_base(4);
        wait_frame_start();
        capture_reads("wrap addresses", 4, '{4, 5, 0, 1});

        scroll_en = 1;
        repeat (SDIV * 14) tick();

        scroll_en = 0;
        msg_len   = 2;
        wait_frame_start();
        pulses = 0;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (rd_enable) pulses++;
        end
        check_value("len2 read pulses", pulses, 2);

        msg_len = 0;
        wait_frame_start();
        pulses = 0;
        lit    = 0;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (rd_enable) pulses++;
            if (seg_out != 8'hFF) lit++;
        end
        check_value("len0 read pulses", pulses, 0);
        check_value("len0 lit cycles", lit, 0);

        msg_len   = 6;
        scroll_en = 1;
        seek_base(5);
        msg_len = 3;
        wait_frame_start();
        capture_reads("shrink addresses", 3, '{0, 1, 2, 0});

        msg_len = 4;
        wait_frame_start();
        tick();
        rst = 1;
        tick();
        check_value("midscan rst rd_enable", int'(rd_enable), 0);
        check_value("midscan rst digit_sel", int'(digit_sel), 4'hF);
        check_value("midscan rst seg_out", int'(seg_out), 8'hFF);
        rst = 0;
        capture_reads("restart address", 1, '{0, 0, 0, 0});

        scroll_en = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (rst) rst = 0;
            else if ($urandom_range(0, 399) == 0) rst = 1;
            if ($urandom_range(0, 59) == 0) scroll_en = ~scroll_en;
            if ($urandom_range(0, 249) == 0) msg_len = pick_len();
        end
        rst = 0;
        repeat (FRAME) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
